// File: rtl/rggen_wide_register.sv
// Wide register block: splits a DATA_WIDTH register over several bus words with buffered commits and snapshot reads.
// Optional macro RGGEN_WIDE_REGISTER_COHERENCY_CHECK_EN turns incoherent accesses into SLVERR responses.
module rggen_wide_register #(
    parameter bit READABLE       = 1'b1,
    parameter bit WRITABLE       = 1'b1,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int OFFSET_ADDRESS = 0,
    parameter int BUS_WIDTH      = 32,
    parameter int DATA_WIDTH     = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic                     i_write,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic [BUS_WIDTH-1:0]     i_write_data,
    input  logic [BUS_WIDTH-1:0]     i_strobe,
    output logic                     o_active,
    output logic                     o_ready,
    output logic [1:0]               o_status,
    output logic [BUS_WIDTH-1:0]     o_read_data,
    output logic                     o_bf_valid,
    output logic                     o_bf_write,
    output logic [DATA_WIDTH-1:0]    o_bf_write_data,
    output logic [DATA_WIDTH-1:0]    o_bf_mask,
    input  logic [DATA_WIDTH-1:0]    i_bf_read_data
);

`ifdef RGGEN_WIDE_REGISTER_COHERENCY_CHECK_EN
    localparam bit COHERENCY_CHECK = 1'b1;
`else
    localparam bit COHERENCY_CHECK = 1'b0;
`endif

    localparam int WORDS = DATA_WIDTH / BUS_WIDTH;
    localparam int LW    = DATA_WIDTH - BUS_WIDTH;
    localparam int BYTES = BUS_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IW    = $clog2(WORDS);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, BF, RESP} state_t;

    state_t                  state_q, state_d;
    logic [LW-1:0]           wbuf_q, wbuf_d;
    logic [LW-1:0]           mbuf_q, mbuf_d;
    logic [WORDS-2:0]        wmark_q, wmark_d;
    logic [DATA_WIDTH-1:0]   shadow_q, shadow_d;
    logic                    shadow_valid_q, shadow_valid_d;
    logic                    ready_q, ready_d;
    logic [1:0]              status_q, status_d;
    logic [BUS_WIDTH-1:0]    read_data_q, read_data_d;
    logic                    bf_valid_q, bf_valid_d;
    logic                    bf_write_q, bf_write_d;
    logic [DATA_WIDTH-1:0]   bf_write_data_q, bf_write_data_d;
    logic [DATA_WIDTH-1:0]   bf_mask_q, bf_mask_d;

    logic [ADDRESS_WIDTH-1:0] offset_diff;
    logic [ADDRESS_WIDTH-1:0] word_index_full;
    logic [IW-1:0]            word_index;
    logic                     match;

    // Subtraction wraps for addresses below the offset, so they fall out of range too.
    assign offset_diff     = i_address - ADDRESS_WIDTH'(OFFSET_ADDRESS);
    assign word_index_full = offset_diff >> LSB;
    assign word_index      = word_index_full[IW-1:0];
    assign match           = ((offset_diff & ADDRESS_WIDTH'(BYTES - 1)) == '0) &&
                             (word_index_full < ADDRESS_WIDTH'(WORDS)) &&
                             (i_write ? WRITABLE : READABLE);
    assign o_active        = i_valid & match;

    always_comb begin
        state_d         = state_q;
        wbuf_d          = wbuf_q;
        mbuf_d          = mbuf_q;
        wmark_d         = wmark_q;
        shadow_d        = shadow_q;
        shadow_valid_d  = shadow_valid_q;
        ready_d         = 1'b0;
        status_d        = OKAY;
        read_data_d     = '0;
        bf_valid_d      = 1'b0;
        bf_write_d      = 1'b0;
        bf_write_data_d = '0;
        bf_mask_d       = '0;
        case (state_q)
            IDLE: begin
                if (o_active) begin
                    if (i_write && (word_index != IW'(WORDS - 1))) begin
                        for (int i = 0; i < WORDS - 1; i++) begin
                            if (int'(word_index) == i) begin
                                wbuf_d[i*BUS_WIDTH +: BUS_WIDTH] =
                                    (wbuf_q[i*BUS_WIDTH +: BUS_WIDTH] & ~i_strobe) | (i_write_data & i_strobe);
                                mbuf_d[i*BUS_WIDTH +: BUS_WIDTH] = mbuf_q[i*BUS_WIDTH +: BUS_WIDTH] | i_strobe;
                                wmark_d[i] = 1'b1;
                            end
                        end
                        state_d = RESP;
                        ready_d = 1'b1;
                    end else if (i_write && COHERENCY_CHECK && !(&wmark_q)) begin
                        wbuf_d   = '0;
                        mbuf_d   = '0;
                        wmark_d  = '0;
                        state_d  = RESP;
                        ready_d  = 1'b1;
                        status_d = SLVERR;
                    end else if (i_write) begin
                        state_d         = BF;
                        bf_valid_d      = 1'b1;
                        bf_write_d      = 1'b1;
                        bf_write_data_d = {i_write_data, wbuf_q};
                        bf_mask_d       = {i_strobe, mbuf_q};
                    end else if (word_index == '0) begin
                        state_d    = BF;
                        bf_valid_d = 1'b1;
                        bf_mask_d  = '1;
                    end else begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        if (COHERENCY_CHECK && !shadow_valid_q) begin
                            status_d = SLVERR;
                        end else begin
                            for (int i = 1; i < WORDS; i++) begin
                                if (int'(word_index) == i) begin
                                    read_data_d = shadow_q[i*BUS_WIDTH +: BUS_WIDTH];
                                end
                            end
                        end
                    end
                end
            end
            BF: begin
                state_d = RESP;
                ready_d = 1'b1;
                if (bf_write_q) begin
                    wbuf_d         = '0;
                    mbuf_d         = '0;
                    wmark_d        = '0;
                    shadow_valid_d = 1'b0;
                end else begin
                    shadow_d       = i_bf_read_data;
                    shadow_valid_d = 1'b1;
                    read_data_d    = i_bf_read_data[BUS_WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= IDLE;
            wbuf_q          <= '0;
            mbuf_q          <= '0;
            wmark_q         <= '0;
            shadow_q        <= '0;
            shadow_valid_q  <= 1'b0;
            ready_q         <= 1'b0;
            status_q        <= OKAY;
            read_data_q     <= '0;
            bf_valid_q      <= 1'b0;
            bf_write_q      <= 1'b0;
            bf_write_data_q <= '0;
            bf_mask_q       <= '0;
        end else begin
            state_q         <= state_d;
            wbuf_q          <= wbuf_d;
            mbuf_q          <= mbuf_d;
            wmark_q         <= wmark_d;
            shadow_q        <= shadow_d;
            shadow_valid_q  <= shadow_valid_d;
            ready_q         <= ready_d;
            status_q        <= status_d;
            read_data_q     <= read_data_d;
            bf_valid_q      <= bf_valid_d;
            bf_write_q      <= bf_write_d;
            bf_write_data_q <= bf_write_data_d;
            bf_mask_q       <= bf_mask_d;
        end
    end

    assign o_ready         = ready_q;
    assign o_status        = status_q;
    assign o_read_data     = read_data_q;
    assign o_bf_valid      = bf_valid_q;
    assign o_bf_write      = bf_write_q;
    assign o_bf_write_data = bf_write_data_q;
    assign o_bf_mask       = bf_mask_q;

endmodule

// File: tb/tb_rggen_wide_register.sv
// Directed bench for rggen_wide_register (BUS_WIDTH=32, DATA_WIDTH=64, register at byte 0x10).
module tb_rggen_wide_register;

`ifdef RGGEN_WIDE_REGISTER_COHERENCY_CHECK_EN
    localparam bit COH = 1'b1;
`else
    localparam bit COH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] strobe = '0;
    logic        active;
    logic        ready;
    logic [1:0]  status;
    logic [31:0] read_data;
    logic        bf_valid;
    logic        bf_write;
    logic [63:0] bf_write_data;
    logic [63:0] bf_mask;
    logic [63:0] bf_read_data = '0;

    int checks = 0;
    int errors = 0;
    int bf_count = 0;
    int ready_count = 0;
    logic        last_bf_write = 1'b0;
    logic [63:0] last_bf_data = '0;
    logic [63:0] last_bf_mask = '0;

    rggen_wide_register #(
        .READABLE(1'b1), .WRITABLE(1'b1), .ADDRESS_WIDTH(8),
        .OFFSET_ADDRESS(8'h10), .BUS_WIDTH(32), .DATA_WIDTH(64)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_write(write),
        .i_address(address), .i_write_data(write_data), .i_strobe(strobe),
        .o_active(active), .o_ready(ready), .o_status(status), .o_read_data(read_data),
        .o_bf_valid(bf_valid), .o_bf_write(bf_write), .o_bf_write_data(bf_write_data),
        .o_bf_mask(bf_mask), .i_bf_read_data(bf_read_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bf_valid) begin
            bf_count++;
            last_bf_write = bf_write;
            last_bf_data  = bf_write_data;
            last_bf_mask  = bf_mask;
        end
        if (ready) ready_count++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts #1 after a posedge with the block idle; returns #1 after a posedge with the block idle.
    task automatic bus_access(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                              input logic [31:0] strb, output logic [31:0] rdata,
                              output logic [1:0] st, output int lat);
        bit got;
        valid = 1'b1; write = wr; address = addr; write_data = wdata; strobe = strb;
        lat = 1; got = 1'b0; rdata = '0; st = '0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk); #1;
            lat++;
            if (ready) begin
                got = 1'b1; rdata = read_data; st = status;
            end
        end
        if (!got) begin
            errors++;
            $display("FAIL timeout addr %h no ready", addr);
        end
        valid = 1'b0; write = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic [1:0]  st;
    int          lat;
    int          bf_before;
    int          rdy_before;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_status", {62'd0, status}, 64'd0);
        check("reset_rdata", {32'd0, read_data}, 64'd0);
        check("reset_bf_valid", {63'd0, bf_valid}, 64'd0);
        check("reset_bf_mask", bf_mask, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Read of upper word straight after reset.
        bf_before = bf_count;
        valid = 1'b1; write = 1'b0; address = 8'h14; #1;
        check("active_word1", {63'd0, active}, 64'd1);
        valid = 1'b0;
        bus_access(1'b0, 8'h14, 32'h0, 32'h0, rd, st, lat);
        check("rd1_rst_lat", 64'(lat), 64'd2);
        check("rd1_rst_data", {32'd0, rd}, 64'd0);
        check("rd1_rst_status", {62'd0, st}, COH ? 64'd2 : 64'd0);
        check("rd1_rst_no_bf", 64'(bf_count - bf_before), 64'd0);

        // Snapshot read: word 0 captures, word 1 reads the snapshot.
        bf_read_data = 64'h1122_3344_5566_7788;
        bf_before = bf_count;
        bus_access(1'b0, 8'h10, 32'h0, 32'h0, rd, st, lat);
        check("rd0_lat", 64'(lat), 64'd3);
        check("rd0_data", {32'd0, rd}, 64'h5566_7788);
        check("rd0_status", {62'd0, st}, 64'd0);
        check("rd0_bf_pulses", 64'(bf_count - bf_before), 64'd1);
        check("rd0_bf_dir", {63'd0, last_bf_write}, 64'd0);
        check("rd0_bf_mask", last_bf_mask, 64'hFFFF_FFFF_FFFF_FFFF);
        bf_read_data = 64'h0;
        bus_access(1'b0, 8'h14, 32'h0, 32'h0, rd, st, lat);
        check("rd1_lat", 64'(lat), 64'd2);
        check("rd1_data", {32'd0, rd}, 64'h1122_3344);
        check("rd1_status", {62'd0, st}, 64'd0);

        // Two-word write commits once on the last word.
        bf_before = bf_count;
        bus_access(1'b1, 8'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFF, rd, st, lat);
        check("wr0_lat", 64'(lat), 64'd2);
        check("wr0_no_bf", 64'(bf_count - bf_before), 64'd0);
        bus_access(1'b1, 8'h14, 32'h0000_CAFE, 32'h0000_FFFF, rd, st, lat);
        check("wr1_lat", 64'(lat), 64'd3);
        check("wr1_status", {62'd0, st}, 64'd0);
        check("wr1_bf_pulses", 64'(bf_count - bf_before), 64'd1);
        check("wr1_bf_dir", {63'd0, last_bf_write}, 64'd1);
        check("wr1_bf_data", last_bf_data, 64'h0000_CAFE_DEAD_BEEF);
        check("wr1_bf_mask", last_bf_mask, 64'h0000_FFFF_FFFF_FFFF);
        // Shadow is untouched by writes; the commit only invalidates it.
        bus_access(1'b0, 8'h14, 32'h0, 32'h0, rd, st, lat);
        check("rd1_after_wr_data", {32'd0, rd}, COH ? 64'd0 : 64'h1122_3344);
        check("rd1_after_wr_status", {62'd0, st}, COH ? 64'd2 : 64'd0);

        // Repeated lower-word writes merge; an interleaved read leaves the buffer alone.
        bus_access(1'b1, 8'h10, 32'h0000_00FF, 32'h0000_00FF, rd, st, lat);
        bus_access(1'b0, 8'h14, 32'h0, 32'h0, rd, st, lat);
        bus_access(1'b1, 8'h10, 32'hFF00_0000, 32'hFF00_0000, rd, st, lat);
        bus_access(1'b1, 8'h14, 32'h1234_5678, 32'hFFFF_FFFF, rd, st, lat);
        check("merge_bf_data", last_bf_data, 64'h1234_5678_FF00_00FF);
        check("merge_bf_mask", last_bf_mask, 64'hFFFF_FFFF_FF00_00FF);
        // Lone last-word write: buffers were cleared by the previous commit.
        bf_before = bf_count;
        bus_access(1'b1, 8'h14, 32'h8765_4321, 32'hFFFF_FFFF, rd, st, lat);
        check("lone_lat", 64'(lat), COH ? 64'd2 : 64'd3);
        check("lone_status", {62'd0, st}, COH ? 64'd2 : 64'd0);
        check("lone_bf_pulses", 64'(bf_count - bf_before), COH ? 64'd0 : 64'd1);
        check("lone_bf_data", last_bf_data, COH ? 64'h1234_5678_FF00_00FF : 64'h8765_4321_0000_0000);
        check("lone_bf_mask", last_bf_mask, COH ? 64'hFFFF_FFFF_FF00_00FF : 64'hFFFF_FFFF_0000_0000);

        // Reset while the commit is on the bit-field interface.
        bus_access(1'b1, 8'h10, 32'hAAAA_AAAA, 32'hFFFF_FFFF, rd, st, lat);
        rdy_before = ready_count;
        valid = 1'b1; write = 1'b1; address = 8'h14; write_data = 32'h5555_5555; strobe = '1;
        @(posedge clk); #1;
        check("mid_bf_valid", {63'd0, bf_valid}, 64'd1);
        rst = 1'b1; #1;
        check("mid_rst_bf_valid", {63'd0, bf_valid}, 64'd0);
        check("mid_rst_bf_write", {63'd0, bf_write}, 64'd0);
        check("mid_rst_bf_data", bf_write_data, 64'd0);
        check("mid_rst_bf_mask", bf_mask, 64'd0);
        check("mid_rst_ready", {63'd0, ready}, 64'd0);
        valid = 1'b0; write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_no_resp", 64'(ready_count - rdy_before), 64'd0);
        bus_access(1'b0, 8'h14, 32'h0, 32'h0, rd, st, lat);
        check("post_rst_rd1_data", {32'd0, rd}, 64'd0);
        check("post_rst_rd1_status", {62'd0, st}, COH ? 64'd2 : 64'd0);

        // Unmatched accesses are ignored.
        rdy_before = ready_count;
        bf_before = bf_count;
        valid = 1'b1; write = 1'b1; address = 8'h18; write_data = 32'hFFFF_FFFF; strobe = '1; #1;
        check("oor_active", {63'd0, active}, 64'd0);
        repeat (4) @(posedge clk);
        #1;
        write = 1'b0; address = 8'h11; #1;
        check("misaligned_active", {63'd0, active}, 64'd0);
        repeat (4) @(posedge clk);
        #1;
        valid = 1'b0;
        check("unmatched_no_ready", 64'(ready_count - rdy_before), 64'd0);
        check("unmatched_no_bf", 64'(bf_count - bf_before), 64'd0);
        @(posedge clk); #1;
        bus_access(1'b0, 8'h14, 32'h0, 32'h0, rd, st, lat);
        check("after_unmatched_lat", 64'(lat), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
